pc_sequencer: RTL

16-bit program-counter controller for the 6502 core. Owns PCL/PCH and sequences them through two chained 8-bit increment stages, 6502-style, for increment, load and relative-branch commands. Sits between the instruction decoder, which issues commands, and the address bus mux, which consumes `pc`. Models the extra branch-fixup cycle on a page crossing.

---
 rtl/pc_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// 16-bit program-counter controller for the 6502 core. Holds PCL/PCH and
// updates them through two chained 8-bit incrementers for INC, LOAD, NOP and
// relative BRANCH commands issued by the instruction decoder. The registered
// program counter feeds the address bus mux.
//
// Optional feature macro: PC_PAGE_CROSS_PENALTY_EN
//   defined   : a page-crossing BRANCH writes {PCH, lo}, spends one extra
//               FIXUP cycle correcting PCH (cycle-accurate 6502 timing).
//   undefined : a page-crossing BRANCH completes in one cycle; FIXUP is never
//               entered and o_busy is tied low.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_cmd_valid    command present this cycle
//   i_cmd          00 INC, 01 LOAD, 10 BRANCH, 11 NOP
//   o_cmd_ready    command accepted when i_cmd_valid & o_cmd_ready
//   i_load_addr    LOAD target
//   i_offset       signed 8-bit branch displacement
//   i_rdy          6502 RDY; low freezes all state
//   o_pc           registered program counter
//   o_busy         high while in FIXUP
//   o_page_cross   one-cycle pulse: a branch crossed a page
//   o_wrap         one-cycle pulse: INC wrapped FFFF -> 0000
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [15:0] RESET_PC = 16'hFFFC
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    input  logic [1:0]  i_cmd,
    output logic        o_cmd_ready,
    input  logic [15:0] i_load_addr,
    input  logic [7:0]  i_offset,
    input  logic        i_rdy,
    output logic [15:0] o_pc,
    output logic        o_busy,
    output logic        o_page_cross,
    output logic        o_wrap
);

    typedef enum logic [1:0] {
        CMD_INC    = 2'b00,
        CMD_LOAD   = 2'b01,
        CMD_BRANCH = 2'b10,
        CMD_NOP    = 2'b11
    } cmd_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FIXUP = 1'b1
    } state_e;

    state_e      r_state;
    logic [7:0]  r_pch;
    logic [7:0]  r_pcl;
    logic        r_wrap;
    logic        r_page_cross;

    logic        w_cmd_ready;
    logic        w_accept;
    logic [8:0]  w_inc_lo;
    logic [7:0]  w_inc_hi;
    logic [8:0]  w_br_sum;
    logic        w_br_cross;

    // NOTE: ready is a plain combinational function of rdy, reset and the
    // current state so the decoder sees acceptance in the same cycle.
    assign w_cmd_ready = i_rdy & ~i_rst & (r_state == S_IDLE);
    assign w_accept    = i_cmd_valid & w_cmd_ready;

    // Low incrementer carry-out feeds the high incrementer carry-in.
    assign w_inc_lo = {1'b0, r_pcl} + 9'd1;
    assign w_inc_hi = r_pch + {7'd0, w_inc_lo[8]};

    // Branch low-byte add. A positive offset crosses on carry; a negative
    // offset (sign-extended with FF) crosses when there is no carry.
    assign w_br_sum   = {1'b0, r_pcl} + {1'b0, i_offset};
    assign w_br_cross = i_offset[7] ? ~w_br_sum[8] : w_br_sum[8];

`ifdef PC_PAGE_CROSS_PENALTY_EN
    logic       r_neg;
    logic [7:0] w_fix_pch;

    // Direction of the PCH correction comes from the sign latched at acceptance.
    assign w_fix_pch = r_neg ? (r_pch - 8'd1) : (r_pch + 8'd1);
    assign o_busy    = (r_state == S_FIXUP);
`else
    logic [7:0] w_adj_pch;

    assign w_adj_pch = i_offset[7] ? (r_pch - 8'd1) : (r_pch + 8'd1);
    assign o_busy    = 1'b0;
`endif

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_pch        <= RESET_PC[15:8];
            r_pcl        <= RESET_PC[7:0];
            r_wrap       <= 1'b0;
            r_page_cross <= 1'b0;
`ifdef PC_PAGE_CROSS_PENALTY_EN
            r_neg        <= 1'b0;
`endif
        end else begin
            // Pulses last one cycle; they are only set on an enabled cycle.
            r_wrap       <= 1'b0;
            r_page_cross <= 1'b0;
            if (i_rdy) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            case (cmd_e'(i_cmd))
                                CMD_INC: begin
                                    r_pcl  <= w_inc_lo[7:0];
                                    r_pch  <= w_inc_hi;
                                    r_wrap <= (r_pch == 8'hFF) && (r_pcl == 8'hFF);
                                end
                                CMD_LOAD: begin
                                    r_pch <= i_load_addr[15:8];
                                    r_pcl <= i_load_addr[7:0];
                                end
                                CMD_BRANCH: begin
                                    r_pcl <= w_br_sum[7:0];
`ifdef PC_PAGE_CROSS_PENALTY_EN
                                    if (w_br_cross) begin
                                        r_neg   <= i_offset[7];
                                        r_state <= S_FIXUP;
                                    end
`else
                                    if (w_br_cross) begin
                                        r_pch        <= w_adj_pch;
                                        r_page_cross <= 1'b1;
                                    end
`endif
                                end
                                CMD_NOP: ;
                            endcase
                        end
                    end
                    S_FIXUP: begin
`ifdef PC_PAGE_CROSS_PENALTY_EN
                        r_pch        <= w_fix_pch;
                        r_page_cross <= 1'b1;
`endif
                        r_state      <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_cmd_ready  = w_cmd_ready;
    assign o_pc         = {r_pch, r_pcl};
    assign o_wrap       = r_wrap;
    assign o_page_cross = r_page_cross;

endmodule
